m68k_bus_responder: RTL and testbench

Emulated 68000 bus target: the responding end of the 68000 asynchronous bus the PiStorm CPLD drives as initiator. Decodes AS_n/UDS_n/LDS_n/RW/FC and the address bus, serves word/byte reads and writes from an internal RAM, and terminates each cycle with DTACK_n after programmable wait states. Used as an on-board target and bench model for exercising the initiator state machine, including its DTACK wait loop.

---
 rtl/m68k_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: emulated 68000 asynchronous bus target.
// The initiator's bus strobes are synchronised into PI_CLK. A cycle is decoded
// against BASE/MASK and served from an internal 2^AW x 16 RAM. Each cycle is
// terminated with DTACK_n after WAIT_STATES further clocks.
module m68k_bus_responder #(
  parameter int          AW          = 10,
  parameter logic [22:0] BASE        = 23'h7C0000,
  parameter logic [22:0] MASK        = 23'h7FFC00,
  parameter int          WAIT_STATES = 4
) (
  input  logic        PI_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:1] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic [15:0] ACCESS_COUNT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_SKIP    = 3'd5;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // Two-flop synchronisers; _p1 is the usable, metastability-filtered copy.
  logic as_n_p0, as_n_p1;
  logic uds_n_p0, uds_n_p1;
  logic lds_n_p0, lds_n_p1;
  logic rw_p0, rw_p1;

  logic [2:0] state, state_nx;
  logic [3:0] wait_cnt;

  // RAM is split into byte lanes so that partial writes need no read-modify-write.
  logic [7:0] ram_hi [0:(1<<AW)-1];
  logic [7:0] ram_lo [0:(1<<AW)-1];

  logic          sel;
  logic          strobe;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] word_idx;

  // A, FC and D_IN are only looked at in DECODE, where a synced-low AS_n and
  // data strobe guarantee the initiator has held them stable for several clocks.
  assign sel      = ((M68K_A & MASK) == (BASE & MASK)) && (M68K_FC != 3'b111);
  assign strobe   = !uds_n_p1 || !lds_n_p1;
  assign word_idx = M68K_A[AW:1];
  assign start    = (state == S_DECODE) && (state_nx == S_WAIT);
  assign wr_en    = start && !rw_p1;

  // Synchronise the asynchronous strobes and RW; reset to the bus-idle levels.
  always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      as_n_p0  <= 1'b1;
      as_n_p1  <= 1'b1;
      uds_n_p0 <= 1'b1;
      uds_n_p1 <= 1'b1;
      lds_n_p0 <= 1'b1;
      lds_n_p1 <= 1'b1;
      rw_p0    <= 1'b1;
      rw_p1    <= 1'b1;
    end else begin
      as_n_p0  <= M68K_AS_n;
      as_n_p1  <= as_n_p0;
      uds_n_p0 <= M68K_UDS_n;
      uds_n_p1 <= uds_n_p0;
      lds_n_p0 <= M68K_LDS_n;
      lds_n_p1 <= lds_n_p0;
      rw_p0    <= M68K_RW;
      rw_p1    <= rw_p0;
    end
  end

  // Bus-cycle sequencing; an early AS_n release always exits through RELEASE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (!as_n_p1) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (as_n_p1)     state_nx = S_RELEASE;
        else if (!sel)   state_nx = S_SKIP;
        else if (strobe) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (as_n_p1)              state_nx = S_RELEASE;
        else if (wait_cnt == 4'd0) state_nx = S_ACK;
      end
      S_ACK: begin
        if (as_n_p1) state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        state_nx = S_IDLE;
      end
      S_SKIP: begin
        if (as_n_p1) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      if (start)
        wait_cnt <= WAIT_LOAD;
      else if ((state == S_WAIT) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Registered bus outputs and the completed-cycle counter.
  always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      M68K_D_OUT   <= 16'd0;
      M68K_D_OE    <= 1'b0;
      M68K_DTACK_n <= 1'b1;
      ACCESS_COUNT <= 16'd0;
    end else begin
      M68K_DTACK_n <= (state_nx != S_ACK);
      if (start) begin
        M68K_D_OE <= rw_p1;
        if (rw_p1)
          M68K_D_OUT <= {ram_hi[word_idx], ram_lo[word_idx]};
      end else if ((state_nx == S_WAIT) || (state_nx == S_ACK)) begin
        // Drop the drivers at once should the initiator turn the bus round.
        M68K_D_OE <= M68K_D_OE && rw_p1;
      end else begin
        M68K_D_OE <= 1'b0;
      end
      if ((state == S_ACK) && (state_nx == S_RELEASE))
        ACCESS_COUNT <= ACCESS_COUNT + 16'd1;
    end
  end

  // Write the enabled byte lanes on the edge that enters WAIT.
  always_ff @(posedge PI_CLK) begin
    if (wr_en && !uds_n_p1) ram_hi[word_idx] <= M68K_D_IN[15:8];
    if (wr_en && !lds_n_p1) ram_lo[word_idx] <= M68K_D_IN[7:0];
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: three instances at distinct bases
// (WAIT_STATES 4, 0 and 8) share one emulated initiator.
module tb_m68k_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] a = '0;
  logic [2:0]  fc = 3'd5;
  logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [15:0] d_in = '0;

  logic [15:0] d_out   [3];
  logic        d_oe    [3];
  logic        dtack_n [3];
  logic [15:0] acc     [3];

  int ws [3] = '{4, 0, 8};
  int exp_cnt [3] = '{0, 0, 0};
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          tgt;
    logic [22:0] addr;
    logic [2:0]  fc;
    logic        uds;
    logic        lds;
    logic        rw;
    logic [15:0] wd;
    logic        ack;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    int          tgt;
    logic [15:0] data;
    logic        oe;
    int          lat;
  } exp_t;

  exp_t sbq [$];
  vec_t tbl [$];

  always #5 clk = ~clk;

  m68k_bus_responder #(.AW(10), .BASE(23'h7C0000), .MASK(23'h7FFC00), .WAIT_STATES(4)) u_ws4 (
    .PI_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(d_in),
    .M68K_D_OUT(d_out[0]), .M68K_D_OE(d_oe[0]), .M68K_DTACK_n(dtack_n[0]), .ACCESS_COUNT(acc[0]));

  m68k_bus_responder #(.AW(10), .BASE(23'h3C0000), .MASK(23'h7FFC00), .WAIT_STATES(0)) u_ws0 (
    .PI_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(d_in),
    .M68K_D_OUT(d_out[1]), .M68K_D_OE(d_oe[1]), .M68K_DTACK_n(dtack_n[1]), .ACCESS_COUNT(acc[1]));

  m68k_bus_responder #(.AW(10), .BASE(23'h1C0000), .MASK(23'h7FFC00), .WAIT_STATES(8)) u_ws8 (
    .PI_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(d_in),
    .M68K_D_OUT(d_out[2]), .M68K_D_OE(d_oe[2]), .M68K_DTACK_n(dtack_n[2]), .ACCESS_COUNT(acc[2]));

  // DTACK_n high-gap monitor for the zero-wait instance.
  int   hi_run = 0;
  int   last_gap = -1;
  int   low_onsets = 0;
  logic prev_dt = 1'b1;
  always @(negedge clk) begin
    if (dtack_n[1]) hi_run++;
    else begin
      if (prev_dt) begin
        last_gap = hi_run;
        low_onsets++;
      end
      hi_run = 0;
    end
    prev_dt = dtack_n[1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int t, input logic [22:0] ad, input logic [2:0] f,
                              input logic u, input logic l, input logic r,
                              input logic [15:0] w, input logic k, input logic [15:0] d);
    vec_t v;
    v.tgt = t; v.addr = ad; v.fc = f; v.uds = u; v.lds = l; v.rw = r;
    v.wd = w; v.ack = k; v.rd = d;
    return v;
  endfunction

  // One complete initiator cycle: AS_n first, data strobes one clock later.
  task automatic bus_cycle(input vec_t v, input int idle);
    int   n;
    bit   seen;
    bit   other_low;
    bit   any_oe;
    exp_t e;
    @(negedge clk);
    a = v.addr; fc = v.fc; rw = v.rw; d_in = v.wd; as_n = 1'b0;
    @(negedge clk);
    uds_n = !v.uds; lds_n = !v.lds;
    if (v.ack) begin
      e.tgt = v.tgt; e.data = v.rd; e.oe = v.rw; e.lat = ws[v.tgt] + 4;
      sbq.push_back(e);
    end
    n = 0; seen = 0; other_low = 0; any_oe = 0;
    while (!seen && n < (v.ack ? 40 : 24)) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (i != v.tgt && !dtack_n[i]) other_low = 1;
        if (!v.ack && d_oe[i]) any_oe = 1;
      end
      if (!dtack_n[v.tgt]) seen = 1;
    end
    chk("foreign_dtack", other_low, 0);
    if (v.ack) begin
      chk("dtack_seen", seen, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (seen) begin
          chk("dtack_latency", n, e.lat);
          chk("d_oe_at_ack", d_oe[e.tgt], e.oe);
          if (e.oe) chk("read_data", d_out[e.tgt], e.data);
        end
      end
    end else begin
      chk("unselected_dtack", seen, 0);
      chk("unselected_oe", any_oe, 0);
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    n = 0;
    while (!dtack_n[v.tgt] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("dtack_release", dtack_n[v.tgt], 1);
    chk("oe_release", d_oe[v.tgt], 0);
    if (v.ack) exp_cnt[v.tgt]++;
    chk("access_count", acc[v.tgt], exp_cnt[v.tgt]);
    repeat (idle) @(negedge clk);
  endtask

  // Cycle on the 8-wait instance abandoned one clock into WAIT.
  task automatic abort_cycle(input logic [22:0] ad, input logic r, input logic [15:0] w);
    bit low;
    @(negedge clk);
    a = ad; fc = 3'd5; rw = r; d_in = w; as_n = 1'b0;
    @(negedge clk);
    uds_n = 1'b0; lds_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_oe_in_wait", d_oe[2], r);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    low = 0;
    repeat (20) begin
      @(negedge clk);
      if (!dtack_n[2]) low = 1;
    end
    chk("abort_no_dtack", low, 0);
    chk("abort_oe_off", d_oe[2], 0);
    chk("abort_count", acc[2], exp_cnt[2]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int onsets0;

    tbl.push_back(mk(0, 23'h7C0008, 3'd5, 1, 1, 0, 16'hBEEF, 1, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0008, 3'd5, 1, 1, 1, 16'h0000, 1, 16'hBEEF));
    tbl.push_back(mk(0, 23'h7C0008, 3'd5, 1, 0, 0, 16'h1234, 1, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0008, 3'd5, 0, 1, 0, 16'h00AB, 1, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0008, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h12AB));
    tbl.push_back(mk(0, 23'h000008, 3'd5, 1, 1, 0, 16'h5555, 0, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0008, 3'd7, 1, 1, 0, 16'h6666, 0, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0008, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h12AB));
    tbl.push_back(mk(0, 23'h7C03FF, 3'd1, 1, 1, 0, 16'hCAFE, 1, 16'h0000));
    tbl.push_back(mk(0, 23'h7C03FF, 3'd2, 0, 1, 1, 16'h0000, 1, 16'hCAFE));
    tbl.push_back(mk(0, 23'h7C0000, 3'd5, 1, 1, 0, 16'h0F0F, 1, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0400, 3'd5, 1, 1, 0, 16'hF0F0, 0, 16'h0000));
    tbl.push_back(mk(0, 23'h7C0000, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h0F0F));
    tbl.push_back(mk(1, 23'h3C0002, 3'd5, 1, 1, 0, 16'h5A5A, 1, 16'h0000));
    tbl.push_back(mk(1, 23'h3C0002, 3'd7, 1, 1, 1, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 23'h3C0002, 3'd6, 1, 1, 1, 16'h0000, 1, 16'h5A5A));

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_dtack", dtack_n[i], 1);
      chk("rst_oe", d_oe[i], 0);
      chk("rst_dout", d_out[i], 0);
      chk("rst_count", acc[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven cycles
    for (int i = 0; i < tbl.size(); i++) bus_cycle(tbl[i], 2);

    // Aborts on the 8-wait instance: the write already entered WAIT, so it lands
    abort_cycle(23'h1C0005, 1'b0, 16'h7777);
    abort_cycle(23'h1C0005, 1'b1, 16'h0000);
    bus_cycle(mk(2, 23'h1C0005, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h7777), 2);

    // Zero-wait back-to-back reads
    onsets0 = low_onsets;
    bus_cycle(mk(1, 23'h3C0002, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h5A5A), 0);
    bus_cycle(mk(1, 23'h3C0002, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h5A5A), 0);
    #1;
    chk("b2b_dtack_pulses", low_onsets - onsets0, 2);
    chk("b2b_gap_ge_1", (last_gap >= 1), 1);

    // Reset asserted while the 4-wait instance sits in ACK
    @(negedge clk);
    a = 23'h7C0008; fc = 3'd5; rw = 1'b1; as_n = 1'b0;
    @(negedge clk);
    uds_n = 1'b0; lds_n = 1'b0;
    n = 0;
    while (dtack_n[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_ack", dtack_n[0], 0);
    chk("pre_reset_oe", d_oe[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dtack", dtack_n[0], 1);
    chk("async_rst_oe", d_oe[0], 0);
    chk("async_rst_count", acc[0], 0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_cycle(mk(0, 23'h7C0008, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h12AB), 2);
    bus_cycle(mk(1, 23'h3C0002, 3'd5, 1, 1, 1, 16'h0000, 1, 16'h5A5A), 2);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
